// File: rtl/color_track_bbox_if.sv
// Mask-stream input and bounding-box result bundle for color_track_bbox.
//   master: drives frame_start/pixel_valid/mask_ready/mask, observes results
//   slave : consumes the mask stream, drives box, centre, count and flags
interface color_track_bbox_if #(
    parameter int unsigned CW = 10,
    parameter int unsigned NW = 19
);
    logic          frame_start;
    logic          pixel_valid;
    logic          mask_ready;
    logic          mask;
    logic [CW-1:0] x_min;
    logic [CW-1:0] x_max;
    logic [CW-1:0] y_min;
    logic [CW-1:0] y_max;
    logic [CW-1:0] center_x;
    logic [CW-1:0] center_y;
    logic [NW-1:0] pixel_count;
    logic          bbox_valid;
    logic          frame_done;
    logic          box_edge;

    modport master (
        output frame_start, pixel_valid, mask_ready, mask,
        input  x_min, x_max, y_min, y_max, center_x, center_y,
        input  pixel_count, bbox_valid, frame_done, box_edge
    );

    modport slave (
        input  frame_start, pixel_valid, mask_ready, mask,
        output x_min, x_max, y_min, y_max, center_x, center_y,
        output pixel_count, bbox_valid, frame_done, box_edge
    );
endinterface

// File: rtl/color_track_bbox.sv
// Per-frame bounding-box extractor for the colour-tracking mask stream.
// Ports:
//   clk_25MHz : pixel clock
//   rst       : synchronous active-high reset
//   bus       : slave side of color_track_bbox_if
//               in : frame_start, pixel_valid, mask_ready, mask
//               out: x_min/x_max/y_min/y_max, center_x/center_y, pixel_count,
//                    bbox_valid, frame_done (1-cycle commit pulse),
//                    box_edge (overlay flag, 1 cycle after the pixel)
module color_track_bbox #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned MIN_PIXELS = 64,
    parameter int unsigned CW         = 10,
    parameter int unsigned NW         = 19
) (
    input logic              clk_25MHz,
    input logic              rst,
    color_track_bbox_if.slave bus
);
    typedef enum logic {ACCUM = 1'b0, COMMIT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] x_q, y_q;
    logic [CW-1:0] amin_x, amax_x, amin_y, amax_y;
    logic [NW-1:0] acnt;
    logic [CW-1:0] bx_min, bx_max, by_min, by_max, cx_q, cy_q;
    logic [NW-1:0] cnt_q;
    logic          valid_q, edge_q;

    logic [CW-1:0] cur_x, cur_y, x_nxt, y_nxt;
    logic [CW-1:0] nmin_x, nmax_x, nmin_y, nmax_y;
    logic [NW-1:0] ncnt;
    logic [CW:0]   sum_x, sum_y;
    logic          hit_c, last_c, commit_c, edge_c;

    // State register; COMMIT is the one cycle following the last pixel
    always_ff @(posedge clk_25MHz) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Next state, raster advance, accumulator next values and overlay test
    always_comb begin
        state_nxt = ACCUM;
        commit_c  = 1'b0;
        cur_x     = bus.frame_start ? '0 : x_q;
        cur_y     = bus.frame_start ? '0 : y_q;
        x_nxt     = cur_x;
        y_nxt     = cur_y;
        hit_c     = bus.pixel_valid & bus.mask_ready & (bus.mask === 1'b1);
        last_c    = bus.pixel_valid && (cur_x == CW'(IMG_WIDTH - 1))
                                    && (cur_y == CW'(IMG_HEIGHT - 1));
        nmin_x    = bus.frame_start ? '1 : amin_x;
        nmax_x    = bus.frame_start ? '0 : amax_x;
        nmin_y    = bus.frame_start ? '1 : amin_y;
        nmax_y    = bus.frame_start ? '0 : amax_y;
        ncnt      = bus.frame_start ? '0 : acnt;

        if (hit_c) begin
            if (cur_x < nmin_x) nmin_x = cur_x;
            if (cur_x > nmax_x) nmax_x = cur_x;
            if (cur_y < nmin_y) nmin_y = cur_y;
            if (cur_y > nmax_y) nmax_y = cur_y;
            if (ncnt != {NW{1'b1}}) ncnt = ncnt + NW'(1);
        end

        if (bus.pixel_valid) begin
            if (cur_x == CW'(IMG_WIDTH - 1)) begin
                x_nxt = '0;
                y_nxt = (cur_y == CW'(IMG_HEIGHT - 1)) ? '0 : cur_y + CW'(1);
            end else begin
                x_nxt = cur_x + CW'(1);
            end
        end

        // frame_start discards the frame, so it suppresses the commit
        if (last_c && !bus.frame_start) begin
            state_nxt = COMMIT;
            commit_c  = 1'b1;
        end

        // Centre from the values being committed, floor of the (CW+1)-bit sum
        sum_x = {1'b0, nmin_x} + {1'b0, nmax_x};
        sum_y = {1'b0, nmin_y} + {1'b0, nmax_y};

        // Outline test against the previously committed box
        edge_c = bus.pixel_valid && valid_q &&
                 ((((cur_x == bx_min) || (cur_x == bx_max)) &&
                   (cur_y >= by_min) && (cur_y <= by_max)) ||
                  (((cur_y == by_min) || (cur_y == by_max)) &&
                   (cur_x >= bx_min) && (cur_x <= bx_max)));
    end

    // Raster position, accumulators, committed result and overlay flag.
    // The commit edge also clears the accumulators, so a pixel arriving in
    // the COMMIT cycle lands in a fresh frame.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            amin_x  <= '1;
            amax_x  <= '0;
            amin_y  <= '1;
            amax_y  <= '0;
            acnt    <= '0;
            bx_min  <= '0;
            bx_max  <= '0;
            by_min  <= '0;
            by_max  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            amin_x <= commit_c ? '1 : nmin_x;
            amax_x <= commit_c ? '0 : nmax_x;
            amin_y <= commit_c ? '1 : nmin_y;
            amax_y <= commit_c ? '0 : nmax_y;
            acnt   <= commit_c ? '0 : ncnt;
            edge_q <= edge_c;
            if (commit_c) begin
                bx_min  <= nmin_x;
                bx_max  <= nmax_x;
                by_min  <= nmin_y;
                by_max  <= nmax_y;
                cx_q    <= sum_x[CW:1];
                cy_q    <= sum_y[CW:1];
                cnt_q   <= ncnt;
                valid_q <= (ncnt >= NW'(MIN_PIXELS));
            end
        end
    end

    assign bus.x_min       = bx_min;
    assign bus.x_max       = bx_max;
    assign bus.y_min       = by_min;
    assign bus.y_max       = by_max;
    assign bus.center_x    = cx_q;
    assign bus.center_y    = cy_q;
    assign bus.pixel_count = cnt_q;
    assign bus.bbox_valid  = valid_q;
    assign bus.frame_done  = (state == COMMIT);
    assign bus.box_edge    = edge_q;
endmodule

// File: tb/tb_color_track_bbox.sv
// Self-checking bench for color_track_bbox on a reduced 32x24 raster.
module tb_color_track_bbox;
    localparam int unsigned W    = 32;
    localparam int unsigned H    = 24;
    localparam int unsigned MINP = 16;
    localparam int unsigned CW   = 6;
    localparam int unsigned NW   = 10;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam int unsigned NMAX = (1 << NW) - 1;

    logic clk_25MHz = 1'b0;
    logic rst;

    always #20 clk_25MHz = ~clk_25MHz;

    color_track_bbox_if #(.CW(CW), .NW(NW)) bus ();

    color_track_bbox #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(MINP), .CW(CW), .NW(NW)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .rst      (rst),
        .bus      (bus)
    );

    // Reference model: committed result, current frame hit list, frame index
    int   e_xmin, e_xmax, e_ymin, e_ymax, e_cx, e_cy, e_cnt;
    bit   e_valid;
    int   pix;
    int   hx[$];
    int   hy[$];
    logic mask_map [H][W];
    bit   rdy_map  [H][W];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_edge_seen, n_done_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit on_box(input int x, input int y);
        return (((x == e_xmin) || (x == e_xmax)) && (y >= e_ymin) && (y <= e_ymax)) ||
               (((y == e_ymin) || (y == e_ymax)) && (x >= e_xmin) && (x <= e_xmax));
    endfunction

    function automatic logic rand_mask();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 1'bx;
        if (r == 1) return 1'bz;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic model_clear_frame();
        pix = 0;
        hx.delete();
        hy.delete();
    endtask

    // Box, centre and count straight from the list of hits of the frame
    task automatic model_commit();
        e_xmin = CMAX; e_xmax = 0; e_ymin = CMAX; e_ymax = 0;
        foreach (hx[i]) begin
            if (hx[i] < e_xmin) e_xmin = hx[i];
            if (hx[i] > e_xmax) e_xmax = hx[i];
            if (hy[i] < e_ymin) e_ymin = hy[i];
            if (hy[i] > e_ymax) e_ymax = hy[i];
        end
        e_cnt   = (hx.size() > NMAX) ? NMAX : hx.size();
        e_cx    = (e_xmin + e_xmax) / 2;
        e_cy    = (e_ymin + e_ymax) / 2;
        e_valid = (e_cnt >= MINP);
    endtask

    task automatic chk_outputs(input string tag);
        logic [63:0] obs, exp;
        obs = 64'({bus.x_min, bus.x_max, bus.y_min, bus.y_max,
                   bus.center_x, bus.center_y, bus.pixel_count, bus.bbox_valid});
        exp = 64'({CW'(e_xmin), CW'(e_xmax), CW'(e_ymin), CW'(e_ymax),
                   CW'(e_cx), CW'(e_cy), NW'(e_cnt), e_valid});
        chk(tag, obs, exp);
    endtask

    // One clock of stimulus, with model update and checks 1 time unit after the edge
    task automatic step(input bit fs, input bit pv, input bit rdy, input logic m);
        bit exp_edge, exp_done;
        int px, py;
        bus.frame_start = fs;
        bus.pixel_valid = pv;
        bus.mask_ready  = rdy;
        bus.mask        = m;
        exp_edge = 1'b0;
        exp_done = 1'b0;
        if (fs) model_clear_frame();
        if (pv) begin
            px = pix % W;
            py = pix / W;
            exp_edge = e_valid && on_box(px, py);
            if (rdy && (m === 1'b1)) begin
                hx.push_back(px);
                hy.push_back(py);
            end
            pix++;
            if (pix == NPIX) begin
                model_commit();
                model_clear_frame();
                exp_done = 1'b1;
            end
        end
        @(posedge clk_25MHz);
        #1;
        chk("box_edge", 64'(bus.box_edge), 64'(exp_edge));
        chk("frame_done", 64'(bus.frame_done), 64'(exp_done));
        chk_outputs(exp_done ? "commit" : "hold");
        if (bus.box_edge === 1'b1) n_edge_seen++;
        if (bus.frame_done === 1'b1) n_done_seen++;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'($urandom_range(0, 1));
        bus.mask_ready  = 1'b1;
        bus.mask        = 1'b1;
        @(posedge clk_25MHz);
        #1;
        rst = 1'b0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        e_cx = 0; e_cy = 0; e_cnt = 0; e_valid = 1'b0;
        model_clear_frame();
        chk("rst_x_min", 64'(bus.x_min), 64'(0));
        chk("rst_x_max", 64'(bus.x_max), 64'(0));
        chk("rst_y_min", 64'(bus.y_min), 64'(0));
        chk("rst_y_max", 64'(bus.y_max), 64'(0));
        chk("rst_center", 64'({bus.center_x, bus.center_y}), 64'(0));
        chk("rst_count", 64'(bus.pixel_count), 64'(0));
        chk("rst_flags", 64'({bus.bbox_valid, bus.frame_done, bus.box_edge}), 64'(0));
    endtask

    task automatic map_clear();
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++) begin
                mask_map[y][x] = 1'b0;
                rdy_map[y][x]  = 1'b1;
            end
    endtask

    task automatic map_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) mask_map[y][x] = 1'b1;
    endtask

    task automatic map_random();
        int x0, x1, y0, y1;
        x0 = int'($urandom_range(0, W - 1));
        x1 = int'($urandom_range(x0, W - 1));
        y0 = int'($urandom_range(0, H - 1));
        y1 = int'($urandom_range(y0, H - 1));
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++) begin
                rdy_map[y][x] = ($urandom_range(0, 99) < 95);
                if (x >= x0 && x <= x1 && y >= y0 && y <= y1)
                    mask_map[y][x] = ($urandom_range(0, 9) == 0) ? rand_mask() : 1'b1;
                else
                    mask_map[y][x] = ($urandom_range(0, 99) < 2) ? rand_mask() : 1'b0;
            end
    endtask

    // Plays the first n pixels of the maps with random idle gaps between them
    task automatic play(input bit with_start, input int gap_pct, input int n);
        for (int p = 0; p < n; p++) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rand_mask());
            step(with_start && (p == 0), 1'b1, rdy_map[p / W][p % W], mask_map[p / W][p % W]);
        end
    endtask

    task automatic chk_rect(input string tag);
        chk({tag, "_x_min"}, 64'(bus.x_min), 64'(5));
        chk({tag, "_x_max"}, 64'(bus.x_max), 64'(14));
        chk({tag, "_y_min"}, 64'(bus.y_min), 64'(3));
        chk({tag, "_y_max"}, 64'(bus.y_max), 64'(12));
        chk({tag, "_center"}, 64'({bus.center_x, bus.center_y}), 64'({CW'(9), CW'(7)}));
        chk({tag, "_count"}, 64'(bus.pixel_count), 64'(100));
        chk({tag, "_valid"}, 64'(bus.bbox_valid), 64'(1));
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.mask_ready  = 1'b0;
        bus.mask        = 1'b0;
        repeat (3) @(posedge clk_25MHz);
        reset_cycle();

        // Single rectangle, no gaps, frame_start on the first pixel
        map_clear();
        map_rect(5, 14, 3, 12);
        n_done_seen = 0;
        play(1'b1, 0, NPIX);
        chk("rect_done_count", 64'(n_done_seen), 64'(1));
        chk_rect("rect");

        // Blank frame: outline of the previous rectangle only
        map_clear();
        n_edge_seen = 0;
        play(1'b0, 0, NPIX);
        chk("overlay_edges", 64'(n_edge_seen), 64'(36));
        chk("overlay_count", 64'(bus.pixel_count), 64'(0));
        chk("overlay_valid", 64'(bus.bbox_valid), 64'(0));

        // Ten isolated hits, below threshold
        map_clear();
        for (int k = 0; k < 10; k++) begin
            int p;
            p = k * 70 + int'($urandom_range(0, 60));
            mask_map[p / W][p % W] = 1'b1;
        end
        play(1'b0, 10, NPIX);
        chk("below_count", 64'(bus.pixel_count), 64'(10));
        chk("below_valid", 64'(bus.bbox_valid), 64'(0));
        map_random();
        n_edge_seen = 0;
        play(1'b0, 10, NPIX);
        chk("below_no_edges", 64'(n_edge_seen), 64'(0));

        // Random frames with gaps, gated and X/Z masks
        for (int f = 0; f < 4; f++) begin
            map_random();
            play(f == 2, 25, NPIX);
        end

        // Rectangle again with heavy gaps
        map_clear();
        map_rect(5, 14, 3, 12);
        play(1'b0, 30, NPIX);
        chk_rect("gaps");

        // Gated mask then a lone hit on the very last pixel
        map_clear();
        for (int p = 0; p < 9; p++) begin
            mask_map[0][p] = 1'b1;
            rdy_map[0][p]  = 1'b0;
        end
        mask_map[H - 1][W - 1] = 1'b1;
        play(1'b0, 5, NPIX);
        chk("gated_count", 64'(bus.pixel_count), 64'(1));
        chk("gated_box", 64'({bus.x_min, bus.x_max, bus.y_min, bus.y_max}),
            64'({CW'(W - 1), CW'(W - 1), CW'(H - 1), CW'(H - 1)}));

        // Mid-frame restart, then an 8x8 block from the new origin
        map_random();
        n_done_seen = 0;
        play(1'b0, 10, 100);
        map_clear();
        map_rect(0, 7, 0, 7);
        play(1'b1, 10, NPIX);
        chk("restart_done_count", 64'(n_done_seen), 64'(1));
        chk("restart_count", 64'(bus.pixel_count), 64'(64));
        chk("restart_valid", 64'(bus.bbox_valid), 64'(1));

        // Reset mid-frame, then one clean frame
        map_random();
        play(1'b0, 10, 300);
        reset_cycle();
        n_done_seen = 0;
        map_random();
        play(1'b0, 10, NPIX - 1);
        chk("post_rst_no_done", 64'(n_done_seen), 64'(0));
        n_done_seen = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("post_rst_done", 64'(n_done_seen), 64'(1));
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/color_track_bbox.md
# color_track_bbox

Per-frame bounding-box extractor sitting directly downstream of the colour-tracking filter in `test_digital_cam_top`. It consumes the raster-ordered `color_track_mask` / `color_track_ready` stream qualified by `pixel_valid`, and accumulates the extent and pixel count of the masked region. At end of frame it commits box coordinates, box centre and count. During the following frame it emits a registered rectangle-outline flag for the VGA overlay mux.

## Interface
Parameters:
- `IMG_WIDTH`, 640, pixels per line in the mask stream
- `IMG_HEIGHT`, 480, lines per frame
- `MIN_PIXELS`, 64, minimum masked-pixel count for a frame to count as a detection
- `CW`, 10, coordinate width; must satisfy `2^CW >= max(IMG_WIDTH, IMG_HEIGHT)`
- `NW`, 19, count width; must satisfy `2^NW >= IMG_WIDTH*IMG_HEIGHT`

Ports (`clk_25MHz` and `rst` first):
- `clk_25MHz`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse; resynchronises the raster position to (0,0)
- `pixel_valid`  in  1  the current cycle carries one raster pixel
- `mask_ready`  in  1  the mask filter output is valid; connects to `color_track_ready`
- `mask`  in  1  masked-colour hit; connects to `color_track_mask`
- `x_min`, `x_max`  out  CW  committed box columns, inclusive
- `y_min`, `y_max`  out  CW  committed box rows, inclusive
- `center_x`, `center_y`  out  CW  committed box centre
- `pixel_count`  out  NW  committed masked-pixel count
- `bbox_valid`  out  1  the committed result is a detection
- `frame_done`  out  1  one-cycle pulse; a new result was committed
- `box_edge`  out  1  overlay flag for the pixel accepted on the previous cycle

## Operation
- **Hit definition:** a hit is `pixel_valid & mask_ready & (mask === 1)`. An X or Z on `mask` is not a hit. When `mask_ready` is low, the pixel still advances position but is not a hit.
- **Raster position:** counters `x` (0..IMG_WIDTH-1) and `y` (0..IMG_HEIGHT-1) advance only on `pixel_valid`.
  - At `x = IMG_WIDTH-1`, `x` wraps to 0 and `y` increments.
  - At the last pixel (`IMG_WIDTH-1`, `IMG_HEIGHT-1`), both wrap to 0 and the frame ends.
- **FSM with two states:**
  - `ACCUM`: the accumulators update on each hit. `amin_x`/`amin_y` take the minimum, `amax_x`/`amax_y` take the maximum, and `acnt` increments, saturating at `2^NW-1`.
  - `COMMIT`: entered for exactly one cycle after the last pixel is accepted.
    - The committed outputs load from the accumulators, including the last pixel's hit.
    - `frame_done` = 1.
    - The accumulators are cleared: min = all-ones, max = 0, count = 0.
    - The FSM returns to `ACCUM`.
    - A `pixel_valid` in this cycle is accepted as pixel (0,0) of the next frame; its hit is written into the freshly cleared accumulators.
- **Detection rule:** `bbox_valid` = (`acnt >= MIN_PIXELS`). When the frame is not a detection, the box and centre outputs are still loaded, but the overlay is suppressed.
- **Centre arithmetic:** `center_x = (x_min + x_max) >> 1` and `center_y = (y_min + y_max) >> 1`. The sum is computed in CW+1 bits and the result is truncated after the shift (floor).
- **frame_start:**
  - Forces `x = y = 0` and clears the accumulators without committing.
  - If `pixel_valid` is high in the same cycle, that pixel is taken as (0,0) and its hit is accumulated.
  - Takes priority over a simultaneous last-pixel commit: no commit occurs and `frame_done` stays 0.
- **Overlay:** `box_edge` is registered. It is 1 when `bbox_valid` is high and the accepted pixel (x,y) satisfies both:
  - (`x == x_min` or `x == x_max`) with `y_min <= y <= y_max`, or (`y == y_min` or `y == y_max`) with `x_min <= x <= x_max`;
  - the comparison uses the committed values from the previous frame.
  
  `box_edge` is 0 on cycles without `pixel_valid`.
- **Empty frame:** count = 0, so `bbox_valid` = 0. The committed min/max are then all-ones/0; treat them as don't-care, since `bbox_valid` gates the overlay.

## Timing
- **Reset values:** all outputs are 0, including `x_min`/`y_min`. The FSM resets to `ACCUM`, `x = y = 0`, and the accumulators are cleared.
- **Reset mid-frame:** the partial frame is discarded and no `frame_done` is issued.
- **Result latency:** committed outputs and `frame_done` are valid on the cycle after the last pixel is accepted. They hold until the next commit or reset.
- **Overlay latency:** `box_edge` lags `pixel_valid` by exactly 1 cycle. Downstream muxing must delay the pixel data by 1 cycle to match.
- **Throughput:** one pixel per cycle with no back-pressure. Gaps in `pixel_valid` are allowed anywhere.
- **Write timing:** the accumulators update on the same edge that accepts the pixel. The committed registers only change on the `COMMIT` edge.

## Test plan
- **Single rectangle:** IMG 640x480, mask = 1 for x 100..199, y 50..149 → `frame_done` pulses once, 1 cycle after pixel 307199. Expected: `x_min` = 100, `x_max` = 199, `y_min` = 50, `y_max` = 149, `center` = (149, 99), `pixel_count` = 10000, `bbox_valid` = 1.
- **Below threshold:** 10 isolated hits, `MIN_PIXELS` = 64 → `pixel_count` = 10, `bbox_valid` = 0, and `box_edge` never asserts in the next frame.
- **Overlay check:** the frame after the rectangle test, all mask = 0 → `box_edge` = 1 one cycle after exactly the border pixels of the previous rectangle (396 pixels), 0 elsewhere. The new commit shows `pixel_count` = 0, `bbox_valid` = 0.
- **Gated mask:** `mask_ready` = 0 for the first 9 pixels while `mask` = 1, then a hit at (639,479) only → count = 1, box = (639,639,479,479). That last-pixel hit must be included in the commit.
- **Mid-frame restart:** `frame_start` pulsed at pixel 1000, then a rectangle at (0..7, 0..7) → count = 64, no `frame_done` at the original frame end, one `frame_done` 307200 valid pixels after the restart.
- **Gaps and reset:** random `pixel_valid` gaps give results identical to the rectangle test. Separately, `rst` asserted at pixel 150000 → all outputs are 0 next cycle and no `frame_done` appears until a full frame completes.
